pipelined_adder: RTL

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes and status flags. It replaces the single-cycle combinational 32-bit adder on paths where a full-width carry chain no longer meets timing, such as the multi-cycle ALU extensions and address generators of the pipelined CPU. The carry chain is split into `STAGES` equal chunks, one chunk resolved per cycle. The block sustains one operation per cycle with backpressure.

---
 rtl/pipelined_adder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES equal chunks, one chunk resolved per cycle, with a valid/ready
// handshake on both sides and a single global advance for the whole pipe.
// in_ready is combinational from out_ready (in_ready = !out_valid || out_ready).
// Legal parameters: WIDTH >= 2, STAGES >= 1, WIDTH % STAGES == 0.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // Whole pipeline moves together; a stalled head freezes every stage.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added enter at the bottom of a_in/b_in.
        localparam int unsigned IN_W  = WIDTH - k * CHUNK;
        localparam int unsigned SUM_W = (k + 1) * CHUNK;

        logic [IN_W-1:0]  a_in;
        logic [IN_W-1:0]  b_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   part;
        logic [SUM_W-1:0] sum_d;
        logic [SUM_W-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        if (k == 0) begin : g_first
            // Subtract is A + ~B + 1: invert B and inject in_sub as carry-in.
            assign a_in  = in_a;
            assign b_in  = in_sub ? ~in_b : in_b;
            assign c_in  = in_sub;
            assign v_in  = in_valid;
            assign sum_d = part[CHUNK-1:0];
        end else begin : g_next
            assign a_in  = g_stage[k-1].g_pass.a_q;
            assign b_in  = g_stage[k-1].g_pass.b_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign v_in  = g_stage[k-1].valid_q;
            assign sum_d = {part[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        // One chunk of the carry chain plus the carry from the chunk below.
        assign part = (CHUNK+1)'(a_in[CHUNK-1:0])
                    + (CHUNK+1)'(b_in[CHUNK-1:0])
                    + (CHUNK+1)'(c_in);

        // Stage register: valid, resolved low sum bits and chunk carry-out.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                carry_q <= part[CHUNK];
                sum_q   <= sum_d;
            end
        end

        if (k < LAST) begin : g_pass
            localparam int unsigned REM_W = IN_W - CHUNK;

            logic [REM_W-1:0] a_q;
            logic [REM_W-1:0] b_q;

            // Carry the unprocessed upper operand bits (including MSBs) forward.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[IN_W-1:CHUNK];
                    b_q <= b_in[IN_W-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            // Flags are resolved as the final chunk lands so outputs come from flops.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (a_in[CHUNK-1] == b_in[CHUNK-1])
                           && (part[CHUNK-1] != a_in[CHUNK-1]);
                    zero_q <= ~|sum_d;
                end
            end

            assign out_valid    = valid_q;
            assign out_sum      = sum_q;
            assign out_carry    = carry_q;
            assign out_overflow = ovf_q;
            assign out_zero     = zero_q;
        end
    end

endmodule
